tile_xy_inj_arb: RTL and testbench

Injection arbiter and credit controller for the tile XY mesh write FIFO. It shares the FIFO's single injection port (`in_en`/`in_datum`/`in_addr`/`insize`) between NREQ local requesters, such as writeback, flush and snoop reply. Round-robin arbitration is combined with an urgent/aging override. Outstanding injections are bounded by a credit counter, and the block honours the FIFO's `wrt_stall` backpressure. It sits between the tile's cache-side request sources and the mesh FIFO instance.

---
 rtl/tile_xy_inj_arb_pkg.sv | 24 ++
 rtl/tile_xy_inj_arb_if.sv | 35 +++
 rtl/tile_xy_inj_arb_rr_prio_pick.sv | 48 ++++
 rtl/tile_xy_inj_arb.sv | 144 ++++++++++++++
 tb/tb_tile_xy_inj_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_xy_inj_arb_pkg.sv
// Shared definitions for the tile XY mesh injection arbiter: payload widths,
// output register state encoding and credit counter sizing.
package tile_xy_inj_arb_pkg;

    localparam int DATA_W = 528;
    localparam int ADDR_W = 37;
    localparam int SIZE_W = 12;
    localparam int IDX_W  = 2;
    localparam int AGE_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STALL
    } inj_state_e;

    // Width needed to hold every value from 0 up to and including the credit limit.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int CREDIT_W = credit_width(8);

endpackage

// File: rtl/tile_xy_inj_arb_if.sv
// Requester and FIFO-injection signals of the mesh write path. The master
// modport is the arbiter side; slave is the requesters plus the FIFO.
interface tile_xy_inj_arb_if
    import tile_xy_inj_arb_pkg::*;
#(
    parameter int NREQ = 3
);

    logic [NREQ-1:0]             req_vld;
    logic [NREQ-1:0]             req_rdy;
    logic [NREQ-1:0]             req_urgent;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][SIZE_W-1:0] req_size;

    logic                        in_en;
    logic [DATA_W-1:0]           in_datum;
    logic [ADDR_W-1:0]           in_addr;
    logic [SIZE_W-1:0]           insize;
    logic                        wrt_stall;
    logic                        credit_ret;

    modport master (
        input  req_vld, req_urgent, req_data, req_addr, req_size,
        input  wrt_stall, credit_ret,
        output req_rdy, in_en, in_datum, in_addr, insize
    );

    modport slave (
        output req_vld, req_urgent, req_data, req_addr, req_size,
        output wrt_stall, credit_ret,
        input  req_rdy, in_en, in_datum, in_addr, insize
    );

endinterface

// File: rtl/tile_xy_inj_arb_rr_prio_pick.sv
// Combinational winner pick: lowest-index urgent requester if any is urgent,
// otherwise round-robin starting one past the last winner.
module rr_prio_pick
    import tile_xy_inj_arb_pkg::*;
#(
    parameter int NREQ = 3
)(
    input  logic [NREQ-1:0]  vld,
    input  logic [NREQ-1:0]  urg,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  urg_vld;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Urgent requesters bypass fairness entirely; otherwise rotate from ptr+1.
    always_comb begin
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        cand    = '0;
        urg_vld = urg & vld;
        if (|urg_vld) begin
            for (int i = 0; i < NREQ; i++) begin
                if (urg_vld[i] && !found) begin
                    found = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NREQ);
                if (vld[cand] && !found) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
        if (found) onehot[idx] = 1'b1;
    end

    assign any = |vld;

endmodule

// File: rtl/tile_xy_inj_arb.sv
// Injection arbiter and credit controller in front of the tile mesh write FIFO.
// Shares one registered injection port among NREQ requesters, bounds the beats
// in flight with a credit counter and holds the beat while the FIFO stalls.
module tile_xy_inj_arb
    import tile_xy_inj_arb_pkg::*;
#(
    parameter int tile_X  = 0,
    parameter int tile_Y  = 0,
    parameter int NREQ    = 3,
    parameter int CREDITS = 8,
    parameter int AGE_MAX = 15
)(
    input  logic                clk,
    input  logic                rst,
    tile_xy_inj_arb_if.master   bus,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err,
    output logic [11:0]         grant_tag
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [AGE_W-1:0]    AGE_LIMIT  = AGE_W'(AGE_MAX);

    inj_state_e                  state_q, state_d;
    logic [DATA_W-1:0]           datum_q, datum_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [SIZE_W-1:0]           size_q, size_d;
    logic [CREDIT_W-1:0]         credit_q, credit_d;
    logic                        credit_err_q, credit_err_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            last_idx_q, last_idx_d;
    logic [NREQ-1:0][AGE_W-1:0]  age_q, age_d;

    logic [NREQ-1:0]  eff_urg;
    logic [NREQ-1:0]  pick_oh;
    logic [NREQ-1:0]  req_rdy;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             in_en;
    logic             can_load;
    logic             grant;

    // A requester that has waited AGE_MAX cycles is treated as urgent.
    always_comb begin
        eff_urg = '0;
        for (int i = 0; i < NREQ; i++) begin
            eff_urg[i] = bus.req_urgent[i] | (age_q[i] == AGE_LIMIT);
        end
    end

    rr_prio_pick #(.NREQ(NREQ)) u_pick (
        .vld    (bus.req_vld),
        .urg    (eff_urg),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign in_en    = (state_q != IDLE);
    assign can_load = (credit_q != '0) && (!in_en || !bus.wrt_stall);
    assign grant    = can_load && pick_any && !rst;
    assign req_rdy  = grant ? pick_oh : '0;

    // Output register: load the winner on a grant, otherwise hold under stall or drain.
    always_comb begin
        state_d    = state_q;
        datum_d    = datum_q;
        addr_d     = addr_q;
        size_d     = size_q;
        rr_ptr_d   = rr_ptr_q;
        last_idx_d = last_idx_q;
        if (grant) begin
            state_d    = SEND;
            datum_d    = bus.req_data[pick_idx];
            addr_d     = bus.req_addr[pick_idx];
            size_d     = bus.req_size[pick_idx];
            rr_ptr_d   = pick_idx;
            last_idx_d = pick_idx;
        end else if (in_en && bus.wrt_stall) begin
            state_d = STALL;
        end else begin
            state_d = IDLE;
        end
    end

    // Credit accounting; a return with the counter already full is flagged, not counted.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({grant, bus.credit_ret})
            2'b10: credit_d = credit_q - CREDIT_W'(1);
            2'b01: begin
                if (credit_q == CREDIT_MAX) credit_err_d = 1'b1;
                else                        credit_d     = credit_q + CREDIT_W'(1);
            end
            default: ;
        endcase
    end

    // Per-requester wait age, saturating, cleared on grant or when the request goes away.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_vld[i] || req_rdy[i]) age_d[i] = '0;
            else if (age_q[i] != AGE_LIMIT)    age_d[i] = age_q[i] + AGE_W'(1);
        end
    end

    // State register with synchronous reset; a held beat is discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            datum_q      <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
            rr_ptr_q     <= IDX_W'(NREQ - 1);
            last_idx_q   <= '0;
            age_q        <= '0;
        end else begin
            state_q      <= state_d;
            datum_q      <= datum_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            rr_ptr_q     <= rr_ptr_d;
            last_idx_q   <= last_idx_d;
            age_q        <= age_d;
        end
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.in_en    = in_en;
    assign bus.in_datum = datum_q;
    assign bus.in_addr  = addr_q;
    assign bus.insize   = size_q;
    assign credit_cnt   = credit_q;
    assign credit_err   = credit_err_q;
    assign grant_tag    = {5'(tile_Y), 5'(tile_X), last_idx_q};

endmodule

// File: tb/tb_tile_xy_inj_arb.sv
// Directed scoreboard bench for tile_xy_inj_arb. Stimulus pushes the expected
// grant order; monitors pop and compare on every handshake and FIFO transfer.
module tb_tile_xy_inj_arb;
    import tile_xy_inj_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int TX   = 3;
    localparam int TY   = 5;

    logic                clk;
    logic                rst;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                credit_err;
    logic [11:0]         grant_tag;

    int checks = 0;
    int fails  = 0;
    int grant_q[$];
    int beat_q[$];
    int g_exp;
    int b_exp;

    tile_xy_inj_arb_if #(.NREQ(NREQ)) bus ();

    tile_xy_inj_arb #(
        .tile_X(TX), .tile_Y(TY), .NREQ(NREQ), .CREDITS(8), .AGE_MAX(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err),
        .grant_tag  (grant_tag)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-requester payloads, so each beat identifies its source.
    function automatic logic [DATA_W-1:0] expData(input int i);
        logic [15:0] w;
        w = 16'hC0D0 + 16'(i);
        return {33{w}};
    endfunction

    function automatic logic [ADDR_W-1:0] expAddr(input int i);
        if (i == 1) return 37'h1_2345_6780;
        return 37'h0_0AB0_0000 + 37'(i);
    endfunction

    function automatic logic [SIZE_W-1:0] expSize(input int i);
        return 12'h100 + 12'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] vld, input logic [NREQ-1:0] urg,
                                 input logic stall, input logic ret);
        bus.req_vld    = vld;
        bus.req_urgent = urg;
        bus.wrt_stall  = stall;
        bus.credit_ret = ret;
    endtask

    task automatic expectGrant(input int i);
        grant_q.push_back(i);
        beat_q.push_back(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: every requester handshake must match the next expected winner.
    always @(negedge clk) begin
        if (|(bus.req_vld & bus.req_rdy)) begin
            if (grant_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_grant: req_rdy=%b, expected none", bus.req_rdy);
            end else begin
                g_exp = grant_q.pop_front();
                checkOutput("grant_onehot", 64'(bus.req_rdy), 64'(1) << g_exp);
            end
        end
    end

    // Transfer monitor: every accepted FIFO beat must carry the expected requester fields.
    always @(negedge clk) begin
        if (bus.in_en && !bus.wrt_stall && !rst) begin
            if (beat_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_beat: in_addr=%h, expected no transfer", bus.in_addr);
            end else begin
                b_exp = beat_q.pop_front();
                checks++;
                if (bus.in_datum !== expData(b_exp)) begin
                    fails++;
                    $display("[TB] FAIL beat_datum: got %h, expected %h", bus.in_datum, expData(b_exp));
                end
                checkOutput("beat_addr", 64'(bus.in_addr), 64'(expAddr(b_exp)));
                checkOutput("beat_size", 64'(bus.insize), 64'(expSize(b_exp)));
            end
        end
    end

    // Watchdog so a wedged run still ends with a failure report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios: round-robin drain, credit return, stall hold, aging, overflow, reset.
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i] = expData(i);
            bus.req_addr[i] = expAddr(i);
            bus.req_size[i] = expSize(i);
        end
        rst = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(3'b111, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_rdy", 64'(bus.req_rdy), 64'd0);
        checkOutput("reset_in_en", 64'(bus.in_en), 64'd0);
        checkOutput("reset_in_addr", 64'(bus.in_addr), 64'd0);
        checkOutput("reset_credit_cnt", 64'(credit_cnt), 64'd8);
        checkOutput("reset_credit_err", 64'(credit_err), 64'd0);
        checkOutput("reset_grant_tag", 64'(grant_tag), 64'({5'd5, 5'd3, 2'd0}));
        step();

        $display("[TB] round-robin drain of all credits");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) expectGrant(k % 3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("drain_credit_cnt", 64'(credit_cnt), 64'(8 - k));
            step();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("empty_credit_cnt", 64'(credit_cnt), 64'd0);
            checkOutput("empty_rdy", 64'(bus.req_rdy), 64'd0);
            step();
        end

        $display("[TB] single credit return");
        applyStimulus(3'b111, '0, 1'b0, 1'b1);
        expectGrant(2);
        @(negedge clk);
        checkOutput("ret_cycle_rdy", 64'(bus.req_rdy), 64'd0);
        step();
        applyStimulus(3'b111, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ret_credit_cnt", 64'(credit_cnt), 64'd1);
        step();
        @(negedge clk);
        checkOutput("ret_used_cnt", 64'(credit_cnt), 64'd0);
        checkOutput("ret_used_rdy", 64'(bus.req_rdy), 64'd0);
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, '0, 1'b0, 1'b1);
            step();
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("refill_credit_cnt", 64'(credit_cnt), 64'd8);
        checkOutput("refill_credit_err", 64'(credit_err), 64'd0);
        step();

        $display("[TB] stall holds a single beat");
        applyStimulus(3'b010, '0, 1'b0, 1'b0);
        expectGrant(1);
        step();
        applyStimulus(3'b001, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_in_en", 64'(bus.in_en), 64'd1);
            checkOutput("stall_in_addr", 64'(bus.in_addr), 64'(expAddr(1)));
            checkOutput("stall_rdy", 64'(bus.req_rdy), 64'd0);
            if (k == 0) checkOutput("stall_grant_tag", 64'(grant_tag), 64'({5'd5, 5'd3, 2'd1}));
            step();
        end
        applyStimulus(3'b001, '0, 1'b0, 1'b0);
        expectGrant(0);
        @(negedge clk);
        checkOutput("release_in_addr", 64'(bus.in_addr), 64'(expAddr(1)));
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        checkOutput("stall_done_in_en", 64'(bus.in_en), 64'd0);
        checkOutput("stall_done_cnt", 64'(credit_cnt), 64'd6);
        step();

        $display("[TB] aging promotion against urgent requester");
        applyStimulus(3'b101, 3'b001, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) expectGrant(0);
        for (int k = 0; k < 20; k++) step();
        applyStimulus(3'b111, '0, 1'b0, 1'b1);
        expectGrant(2);
        @(negedge clk);
        checkOutput("aging_credit_cnt", 64'(credit_cnt), 64'd6);
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        checkOutput("aging_done_in_en", 64'(bus.in_en), 64'd0);
        checkOutput("aging_done_cnt", 64'(credit_cnt), 64'd6);
        step();

        $display("[TB] credit overflow flag");
        applyStimulus('0, '0, 1'b0, 1'b1);
        step();
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_credit_cnt", 64'(credit_cnt), 64'd8);
        checkOutput("full_credit_err", 64'(credit_err), 64'd0);
        step();
        applyStimulus('0, '0, 1'b0, 1'b1);
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("overflow_credit_cnt", 64'(credit_cnt), 64'd8);
        checkOutput("overflow_credit_err", 64'(credit_err), 64'd1);
        step();
        step();
        @(negedge clk);
        checkOutput("sticky_credit_err", 64'(credit_err), 64'd1);
        step();

        $display("[TB] reset during stall");
        applyStimulus(3'b010, '0, 1'b0, 1'b0);
        expectGrant(1);
        step();
        applyStimulus('0, '0, 1'b1, 1'b0);
        step();
        step();
        @(negedge clk);
        checkOutput("pre_reset_in_en", 64'(bus.in_en), 64'd1);
        rst = 1'b1;
        applyStimulus(3'b111, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("in_reset_rdy", 64'(bus.req_rdy), 64'd0);
        step();
        rst = 1'b0;
        applyStimulus(3'b111, '0, 1'b0, 1'b0);
        if (beat_q.size() != 0) void'(beat_q.pop_front());
        expectGrant(0);
        @(negedge clk);
        checkOutput("post_reset_in_en", 64'(bus.in_en), 64'd0);
        checkOutput("post_reset_cnt", 64'(credit_cnt), 64'd8);
        checkOutput("post_reset_err", 64'(credit_err), 64'd0);
        step();
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_addr", 64'(bus.in_addr), 64'(expAddr(0)));
        checkOutput("post_reset_grant_cnt", 64'(credit_cnt), 64'd7);
        step();
        step();

        checkOutput("grant_queue_empty", 64'(grant_q.size()), 64'd0);
        checkOutput("beat_queue_empty", 64'(beat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
